// File: rtl/reg_file_pkg.sv
// Shared default constants for the parametrised register file and its read muxes.
package reg_file_pkg;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_NUM_REGS = 16;
   localparam int unsigned DEF_PC_IDX   = DEF_NUM_REGS - 1;
   localparam int unsigned DEF_PC_STEP  = 4;

endpackage

// File: rtl/reg_read_mux.sv
// NUM_REGS:1 word selector over a flattened register array; one instance per read port.
module reg_read_mux
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic [NUM_REGS*DATA_W-1:0] regs,
   input  logic [ADDR_W-1:0]          sel,
   output logic [DATA_W-1:0]          data
);

   always_comb begin
      data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sel == ADDR_W'(i)) begin
            data = regs[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/register_file_param.sv
// Three-read, one-write register file with write-through bypass and an auto-incrementing PC
// stored as one element of the register array.
module register_file_param
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
   parameter int unsigned PC_IDX   = (NUM_REGS == DEF_NUM_REGS) ? DEF_PC_IDX : NUM_REGS - 1,
   parameter int unsigned PC_STEP  = DEF_PC_STEP
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic [DATA_W-1:0] rd_data,
   input  logic              pc_ld,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              pc_inc,
   output logic [DATA_W-1:0] pc_out
);

   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);
   localparam logic [DATA_W-1:0] PC_INC  = DATA_W'(PC_STEP);
   localparam logic [DATA_W-1:0] PC_OFS  = DATA_W'(2 * PC_STEP);

   logic [DATA_W-1:0]          regs_q [NUM_REGS];
   logic [NUM_REGS*DATA_W-1:0] regs_flat;
   logic [DATA_W-1:0]          pc_vis;
   logic                       wr_pc;
   logic                       byp_en;

   assign wr_pc  = wr_en && (wr_addr == PC_ADDR);
   // Bypass is suppressed in reset so read ports show the cleared state.
   assign byp_en = wr_en && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (wr_en && !wr_pc) begin
            regs_q[wr_addr] <= wr_data;
         end
         if (pc_ld) begin
            regs_q[PC_ADDR] <= pc_in;
         end else if (wr_pc) begin
            regs_q[PC_ADDR] <= wr_data;
         end else if (pc_inc) begin
            regs_q[PC_ADDR] <= regs_q[PC_ADDR] + PC_INC;
         end
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
      end
   end

   assign pc_out = regs_q[PC_ADDR];
   // Pipeline-visible PC, as seen two fetch slots ahead.
   assign pc_vis = regs_q[PC_ADDR] + PC_OFS;

   logic [ADDR_W-1:0] port_addr [3];
   logic [DATA_W-1:0] mux_data  [3];
   logic [DATA_W-1:0] port_data [3];

   assign port_addr[0] = ra_addr;
   assign port_addr[1] = rb_addr;
   assign port_addr[2] = rd_addr;

   for (genvar p = 0; p < 3; p++) begin : g_port
      reg_read_mux #(
         .DATA_W   (DATA_W),
         .NUM_REGS (NUM_REGS),
         .ADDR_W   (ADDR_W)
      ) u_mux (
         .regs (regs_flat),
         .sel  (port_addr[p]),
         .data (mux_data[p])
      );

      always_comb begin
         port_data[p] = mux_data[p];
         if (port_addr[p] == PC_ADDR) begin
            port_data[p] = pc_vis;
         end else if (byp_en && (wr_addr == port_addr[p])) begin
            port_data[p] = wr_data;
         end
      end
   end

   assign ra_data = port_data[0];
   assign rb_data = port_data[1];
   assign rd_data = port_data[2];

endmodule

// File: tb/tb_register_file_param.sv
// Self-checking bench: default 32x16 instance plus a 16-bit x 8 instance for the parameter sweep.
module tb_register_file_param;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;

   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  ra_addr, rb_addr, rd_addr;
   logic [31:0] ra_data, rb_data, rd_data;
   logic        pc_ld;
   logic [31:0] pc_in;
   logic        pc_inc;
   logic [31:0] pc_out;

   logic        s_wr_en;
   logic [2:0]  s_wr_addr;
   logic [15:0] s_wr_data;
   logic [2:0]  s_ra_addr, s_rb_addr, s_rd_addr;
   logic [15:0] s_ra_data, s_rb_data, s_rd_data;
   logic        s_pc_ld;
   logic [15:0] s_pc_in;
   logic        s_pc_inc;
   logic [15:0] s_pc_out;

   register_file_param u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .ra_addr (ra_addr),
      .rb_addr (rb_addr),
      .rd_addr (rd_addr),
      .ra_data (ra_data),
      .rb_data (rb_data),
      .rd_data (rd_data),
      .pc_ld   (pc_ld),
      .pc_in   (pc_in),
      .pc_inc  (pc_inc),
      .pc_out  (pc_out)
   );

   register_file_param #(
      .DATA_W   (16),
      .NUM_REGS (8)
   ) u_dut_small (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (s_wr_en),
      .wr_addr (s_wr_addr),
      .wr_data (s_wr_data),
      .ra_addr (s_ra_addr),
      .rb_addr (s_rb_addr),
      .rd_addr (s_rd_addr),
      .ra_data (s_ra_data),
      .rb_data (s_rb_data),
      .rd_data (s_rd_data),
      .pc_ld   (s_pc_ld),
      .pc_in   (s_pc_in),
      .pc_inc  (s_pc_inc),
      .pc_out  (s_pc_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          port;
      string       name;
      logic [31:0] val;
   } exp_t;

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic [3:0]  a, b, d;
      logic        ld;
      logic [31:0] pin;
      logic        inc;
      logic [31:0] ea, eb, ed, epc;
   } vec_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [31:0] actual(input int port);
      case (port)
         0:       return ra_data;
         1:       return rb_data;
         2:       return rd_data;
         3:       return pc_out;
         4:       return {16'h0, s_ra_data};
         5:       return {16'h0, s_rb_data};
         6:       return {16'h0, s_rd_data};
         default: return {16'h0, s_pc_out};
      endcase
   endfunction

   task automatic expect_out(input int port, input string name, input logic [31:0] val);
      exp_t e;
      e.port = port;
      e.name = name;
      e.val  = val;
      sb_q.push_back(e);
   endtask

   task automatic sample_all();
      exp_t        e;
      logic [31:0] act;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         act = actual(e.port);
         n_checks++;
         if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
         end
      end
   endtask

   task automatic settle();
      #2;
      sample_all();
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                        input logic ld, input logic [31:0] pin, input logic inc);
      @(negedge clk);
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      ra_addr = a;
      rb_addr = b;
      rd_addr = d;
      pc_ld   = ld;
      pc_in   = pin;
      pc_inc  = inc;
   endtask

   task automatic reset_dut();
      drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t tbl[10];

   initial begin
      s_wr_en   = 1'b0;
      s_wr_addr = '0;
      s_wr_data = '0;
      s_ra_addr = '0;
      s_rb_addr = '0;
      s_rd_addr = '0;
      s_pc_ld   = 1'b0;
      s_pc_in   = '0;
      s_pc_inc  = 1'b0;

      //          we    wa     wd            a      b      d      ld    pin           inc
      //          ea            eb            ed            epc
      tbl[0] = '{1'b1, 4'd5,  32'hDEADBEEF, 4'd5,  4'd5,  4'd0,  1'b0, 32'h0,        1'b0,
                 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0};
      tbl[1] = '{1'b0, 4'd0,  32'h0,        4'd5,  4'd5,  4'd15, 1'b0, 32'h0,        1'b0,
                 32'hDEADBEEF, 32'hDEADBEEF, 32'h8,        32'h0};
      tbl[2] = '{1'b1, 4'd15, 32'h40,       4'd15, 4'd5,  4'd1,  1'b0, 32'h0,        1'b0,
                 32'h8,        32'hDEADBEEF, 32'h0,        32'h0};
      tbl[3] = '{1'b0, 4'd0,  32'h0,        4'd15, 4'd5,  4'd2,  1'b0, 32'h0,        1'b0,
                 32'h48,       32'hDEADBEEF, 32'h0,        32'h40};
      tbl[4] = '{1'b1, 4'd1,  32'h11,       4'd1,  4'd1,  4'd1,  1'b0, 32'h0,        1'b1,
                 32'h11,       32'h11,       32'h11,       32'h40};
      tbl[5] = '{1'b0, 4'd0,  32'h0,        4'd1,  4'd15, 4'd2,  1'b0, 32'h0,        1'b0,
                 32'h11,       32'h4C,       32'h0,        32'h44};
      tbl[6] = '{1'b1, 4'd15, 32'h2000,     4'd15, 4'd1,  4'd5,  1'b1, 32'h1000,     1'b1,
                 32'h4C,       32'h11,       32'hDEADBEEF, 32'h44};
      tbl[7] = '{1'b0, 4'd0,  32'h0,        4'd15, 4'd1,  4'd5,  1'b0, 32'h0,        1'b0,
                 32'h1008,     32'h11,       32'hDEADBEEF, 32'h1000};
      tbl[8] = '{1'b1, 4'd15, 32'h3000,     4'd2,  4'd2,  4'd15, 1'b0, 32'h0,        1'b1,
                 32'h0,        32'h0,        32'h1008,     32'h1000};
      tbl[9] = '{1'b0, 4'd0,  32'h0,        4'd2,  4'd15, 4'd15, 1'b0, 32'h0,        1'b0,
                 32'h0,        32'h3008,     32'h3008,     32'h3000};

      // Reset: every port reads zero, PC reads 2*step, pc_out zero.
      reset_dut();
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 4'd0, 32'h0, 4'(i), 4'(i), 4'(i), 1'b0, 32'h0, 1'b0);
         expect_out(0, $sformatf("rst_a_r%0d", i), (i == 15) ? 32'h8 : 32'h0);
         expect_out(1, $sformatf("rst_b_r%0d", i), (i == 15) ? 32'h8 : 32'h0);
         expect_out(2, $sformatf("rst_d_r%0d", i), (i == 15) ? 32'h8 : 32'h0);
         expect_out(3, $sformatf("rst_pc_r%0d", i), 32'h0);
         settle();
      end

      // PC increment and wrap.
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 4'd0, 32'h0, 4'd15, 4'd0, 4'd0, 1'b0, 32'h0, 1'b1);
         expect_out(3, $sformatf("inc_pc%0d", k), 32'(4 * k));
         settle();
      end
      drive(1'b0, 4'd0, 32'h0, 4'd15, 4'd0, 4'd0, 1'b1, 32'hFFFFFFFC, 1'b0);
      expect_out(3, "inc_pc3", 32'd12);
      expect_out(0, "inc_rd_pc3", 32'd20);
      settle();
      drive(1'b0, 4'd0, 32'h0, 4'd15, 4'd0, 4'd0, 1'b0, 32'h0, 1'b1);
      expect_out(3, "ld_pc", 32'hFFFFFFFC);
      expect_out(0, "ld_rd_pc_wrap", 32'h4);
      settle();

      // pc_ld beats a same-edge PC write and pc_inc.
      drive(1'b1, 4'd15, 32'h200, 4'd15, 4'd0, 4'd0, 1'b1, 32'h100, 1'b1);
      expect_out(3, "wrap_pc", 32'h0);
      settle();
      drive(1'b0, 4'd0, 32'h0, 4'd15, 4'd15, 4'd0, 1'b0, 32'h0, 1'b0);
      expect_out(3, "prio_pc", 32'h100);
      expect_out(0, "prio_rd_a", 32'h108);
      expect_out(1, "prio_rd_b", 32'h108);
      settle();

      // Table-driven bypass / write / PC priority vectors from a clean state.
      reset_dut();
      foreach (tbl[i]) begin
         drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a, tbl[i].b, tbl[i].d,
               tbl[i].ld, tbl[i].pin, tbl[i].inc);
         expect_out(0, $sformatf("vec%0d_a", i), tbl[i].ea);
         expect_out(1, $sformatf("vec%0d_b", i), tbl[i].eb);
         expect_out(2, $sformatf("vec%0d_d", i), tbl[i].ed);
         expect_out(3, $sformatf("vec%0d_pc", i), tbl[i].epc);
         settle();
      end

      // Reset asserted between edges discards the pending write and PC updates.
      reset_dut();
      drive(1'b1, 4'd3, 32'h55, 4'd3, 4'd3, 4'd3, 1'b0, 32'h0, 1'b0);
      settle();
      drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd3, 4'd3, 1'b0, 32'h0, 1'b0);
      expect_out(0, "r3_written", 32'h55);
      settle();
      drive(1'b1, 4'd3, 32'hAA, 4'd3, 4'd3, 4'd15, 1'b1, 32'h77, 1'b1);
      #1;
      rst_n = 1'b0;
      expect_out(0, "midrst_a", 32'h0);
      expect_out(1, "midrst_b", 32'h0);
      expect_out(2, "midrst_pcread", 32'h8);
      expect_out(3, "midrst_pc", 32'h0);
      #1;
      sample_all();
      drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd3, 4'd15, 1'b0, 32'h0, 1'b0);
      rst_n = 1'b1;
      expect_out(0, "release_a", 32'h0);
      expect_out(2, "release_pcread", 32'h8);
      expect_out(3, "release_pc", 32'h0);
      settle();
      drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd3, 4'd15, 1'b0, 32'h0, 1'b0);
      expect_out(0, "after_a", 32'h0);
      expect_out(3, "after_pc", 32'h0);
      settle();

      // Parameter sweep on the 16-bit, 8-register instance.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         s_wr_en   = 1'b1;
         s_wr_addr = 3'(i);
         s_wr_data = 16'(i);
      end
      @(negedge clk);
      s_wr_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         s_ra_addr = 3'(i);
         s_rb_addr = 3'(i);
         s_rd_addr = 3'(i);
         expect_out(4, $sformatf("sw_a_r%0d", i), (i == 7) ? 32'd15 : 32'(i));
         expect_out(5, $sformatf("sw_b_r%0d", i), (i == 7) ? 32'd15 : 32'(i));
         expect_out(6, $sformatf("sw_d_r%0d", i), (i == 7) ? 32'd15 : 32'(i));
         expect_out(7, $sformatf("sw_pc_r%0d", i), 32'd7);
         settle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected test completion");
      $fatal(1, "timeout");
   end

endmodule
